// File: rtl/jtframe_sort_ctrl_pkg.sv
// Shared constants, state encoding and modulo-24 increment for the sort-order selector.
package jtframe_sort_ctrl_pkg;

  localparam int NPERM = 24;
  localparam int SELW  = 5;
  localparam int CNTW  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LOCK = 2'd2
  } state_t;

  function automatic logic [SELW-1:0] sel_inc(input logic [SELW-1:0] s);
    return (s == SELW'(NPERM - 1)) ? '0 : s + 1'b1;
  endfunction

endpackage

// File: rtl/jtframe_sort_edge.sv
// Vertical-blank rising-edge detector. The history bit resets high so that vb
// already high at reset release does not count as an edge.
module jtframe_sort_edge
  import jtframe_sort_ctrl_pkg::*;
(
  input  logic rst,
  input  logic clk,
  input  logic vb,
  output logic rise
);

  logic vb_l;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vb_l <= 1'b1;
    else     vb_l <= vb;
  end

  assign rise = vb & ~vb_l;

endmodule

// File: rtl/jtframe_sort_ctrl.sv
// Selects one of 24 sort permutations, advancing on vblank either every PERIOD frames
// or on a single-step request; can be frozen with lock/unlock.
module jtframe_sort_ctrl
  import jtframe_sort_ctrl_pkg::*;
#(
  parameter int PERIOD = 60
) (
  input  logic            rst,
  input  logic            clk,
  input  logic            vb,
  input  logic            run,
  input  logic            step,
  input  logic            lock,
  input  logic            unlock,
  output logic [SELW-1:0] sel,
  output logic            locked,
  output logic            wrap
);

  localparam logic [CNTW-1:0] LAST = CNTW'(PERIOD - 1);

  state_t          state, state_nxt;
  logic [CNTW-1:0] cnt, cnt_nxt;
  logic            pend, pend_nxt;
  logic            adv;
  logic            vb_rise;

  jtframe_sort_edge u_edge (
    .rst  (rst),
    .clk  (clk),
    .vb   (vb),
    .rise (vb_rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pend_nxt  = pend;
    adv       = 1'b0;
    case (state)
      LOCK: begin
        cnt_nxt  = '0;
        pend_nxt = 1'b0;
        if (unlock && !lock) state_nxt = run ? RUN : IDLE;
      end
      default: begin
        if (lock) begin
          // A lock freezes the selection even if it lands on a vblank edge.
          state_nxt = LOCK;
          cnt_nxt   = '0;
          pend_nxt  = 1'b0;
        end else begin
          state_nxt = run ? RUN : IDLE;
          adv       = vb_rise && (pend || step || (state == RUN && cnt == LAST));
          pend_nxt  = vb_rise ? 1'b0 : (pend || step);
          if (adv)                          cnt_nxt = '0;
          else if (vb_rise && state == RUN) cnt_nxt = cnt + 1'b1;
          if (!run)                         cnt_nxt = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel    <= '0;
      wrap   <= 1'b0;
      locked <= 1'b0;
      cnt    <= '0;
      pend   <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      pend   <= pend_nxt;
      locked <= (state_nxt == LOCK);
      wrap   <= adv && (sel == SELW'(NPERM - 1));
      if (adv) sel <= sel_inc(sel);
    end
  end

endmodule

// File: tb/tb_jtframe_sort_ctrl.sv
// Drives two selector instances (PERIOD=3 and PERIOD=1) in lockstep and compares
// them every cycle against a frame-level reference model, plus directed checkpoints.
module tb_jtframe_sort_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vb = 1'b0, run = 1'b0, step = 1'b0, lock = 1'b0, unlock = 1'b0;
  logic [4:0] sel3, sel1;
  logic       locked3, locked1, wrap3, wrap1;

  int errs = 0;
  int checks = 0;

  int per[2] = '{3, 1};
  int m_sel[2], m_frames[2];
  bit m_pend[2], m_locked[2], m_running[2], m_vbp[2], m_wrap[2];

  always #5 clk = ~clk;

  jtframe_sort_ctrl #(.PERIOD(3)) dut3 (
    .rst(rst), .clk(clk), .vb(vb), .run(run), .step(step), .lock(lock),
    .unlock(unlock), .sel(sel3), .locked(locked3), .wrap(wrap3)
  );

  jtframe_sort_ctrl #(.PERIOD(1)) dut1 (
    .rst(rst), .clk(clk), .vb(vb), .run(run), .step(step), .lock(lock),
    .unlock(unlock), .sel(sel1), .locked(locked1), .wrap(wrap1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of the reference: frames counted per vblank, one pending request.
  task automatic model_step(input int i);
    bit e, p, adv;
    m_wrap[i] = 1'b0;
    if (rst === 1'b1) begin
      m_sel[i] = 0; m_frames[i] = 0; m_pend[i] = 0;
      m_locked[i] = 0; m_running[i] = 0; m_vbp[i] = 1;
      return;
    end
    e = (vb === 1'b1) && !m_vbp[i];
    m_vbp[i] = (vb === 1'b1);
    if (m_locked[i]) begin
      if (unlock && !lock) begin
        m_locked[i] = 0;
        m_running[i] = run;
      end
    end else if (lock) begin
      m_locked[i] = 1; m_pend[i] = 0; m_frames[i] = 0;
    end else begin
      p   = m_pend[i] || step;
      adv = e && (p || (m_running[i] && m_frames[i] == per[i] - 1));
      m_pend[i] = e ? 1'b0 : p;
      if (adv) m_frames[i] = 0;
      else if (e && m_running[i]) m_frames[i]++;
      if (adv) begin
        m_wrap[i] = (m_sel[i] == 23);
        m_sel[i]  = (m_sel[i] + 1) % 24;
      end
      if (!run) m_frames[i] = 0;
      m_running[i] = run;
    end
  endtask

  task automatic cyc();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    chk("sel3", sel3, m_sel[0]);
    chk("locked3", locked3, m_locked[0]);
    chk("wrap3", wrap3, m_wrap[0]);
    chk("sel1", sel1, m_sel[1]);
    chk("locked1", locked1, m_locked[1]);
    chk("wrap1", wrap1, m_wrap[1]);
  endtask

  task automatic vb_pulse();
    vb = 1'b0; cyc();
    vb = 1'b1; cyc();
  endtask

  task automatic do_reset();
    vb = 1'b0; run = 1'b0; step = 1'b0; lock = 1'b0; unlock = 1'b0;
    rst = 1'b1; cyc(); cyc();
    rst = 1'b0;
  endtask

  initial begin
    int wraps;
    // Reset values, with vb high across reset release
    vb = 1'b1; run = 1'b1;
    cyc(); cyc();
    chk("rst_sel", sel1, 0);
    chk("rst_locked", locked1, 0);
    chk("rst_wrap", wrap1, 0);
    rst = 1'b0;
    repeat (3) cyc();
    chk("vb_high_at_release", sel1, 0);
    vb_pulse();
    chk("first_real_edge", sel1, 1);

    // PERIOD=3: advance every third edge
    do_reset();
    run = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      vb_pulse();
      if (e % 3 == 0) chk("period3_adv", sel3, e / 3);
    end

    // Steps do not accumulate
    do_reset();
    repeat (3) begin step = 1'b1; cyc(); step = 1'b0; end
    vb_pulse();
    chk("step_once_p3", sel3, 1);
    chk("step_once_p1", sel1, 1);
    vb_pulse();
    chk("pend_cleared", sel1, 1);

    // PERIOD=1 wraps once after 24 edges
    do_reset();
    run = 1'b1;
    wraps = 0;
    for (int e = 0; e < 24; e++) begin
      vb = 1'b0; cyc(); if (wrap1) wraps++;
      vb = 1'b1; cyc(); if (wrap1) wraps++;
    end
    vb = 1'b0; cyc(); if (wrap1) wraps++;
    chk("wrap_count", wraps, 1);
    chk("wrap_sel", sel1, 0);

    // Lock at sel=5, then lock-vs-unlock priority, then unlock restarts the counter
    do_reset();
    run = 1'b1;
    repeat (5) vb_pulse();
    chk("pre_lock_sel", sel1, 5);
    lock = 1'b1; cyc(); lock = 1'b0;
    chk("lock_entered", locked1, 1);
    repeat (10) begin
      step = 1'b1; vb = 1'b0; cyc();
      step = 1'b0; vb = 1'b1; cyc();
    end
    chk("lock_hold_sel", sel1, 5);
    chk("lock_hold_locked", locked1, 1);
    lock = 1'b1; unlock = 1'b1; cyc(); lock = 1'b0; unlock = 1'b0; cyc();
    chk("lock_wins", locked1, 1);
    chk("lock_wins_sel", sel1, 5);
    unlock = 1'b1; cyc(); unlock = 1'b0;
    chk("unlocked", locked1, 0);
    repeat (2) vb_pulse();
    chk("cnt_restart_hold", sel3, 1);
    vb_pulse();
    chk("cnt_restart_adv", sel3, 2);

    // Reset with a step pending at sel=17
    do_reset();
    run = 1'b1;
    repeat (17) vb_pulse();
    chk("pre_rst_sel", sel1, 17);
    run = 1'b0; cyc();
    step = 1'b1; cyc(); step = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("async_rst_sel", sel1, 0);
    chk("async_rst_wrap", wrap1, 0);
    cyc();
    rst = 1'b0;
    vb_pulse();
    chk("rst_pend_cleared", sel1, 0);

    // Randomised traffic
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 3) == 0) vb = ~vb;
      if ($urandom_range(0, 39) == 0) run = ~run;
      step   = ($urandom_range(0, 7) == 0);
      lock   = ($urandom_range(0, 39) == 0);
      unlock = ($urandom_range(0, 19) == 0);
      rst    = ($urandom_range(0, 299) == 0);
      cyc();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/jtframe_sort_ctrl.md
JTFRAME_SORT_CTRL -- requirements
Module: jtframe_sort_ctrl

Interface
REQ-001 The block SHALL have parameter PERIOD, default 60: frames between automatic advances; legal range 1..255.
REQ-002 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-003 The block SHALL have port clk  input  1  the single system clock; all state is on its rising edge.
REQ-004 The block SHALL have port vb  input  1  vertical blank level; only its rising edge is used.
REQ-005 The block SHALL have port run  input  1  level; enables automatic advance.
REQ-006 The block SHALL have port step  input  1  one-cycle pulse; requests a single advance.
REQ-007 The block SHALL have port lock  input  1  one-cycle pulse; freezes the current selection.
REQ-008 The block SHALL have port unlock  input  1  one-cycle pulse; releases the freeze.
REQ-009 The block SHALL have port sel  output  5  permutation index 0..23; drives debug_bus[4:0] of jtframe_sort.
REQ-010 The block SHALL have port locked  output  1  high while in LOCK.
REQ-011 The block SHALL have port wrap  output  1  one-cycle pulse when sel goes from 23 to 0.

Function
REQ-012 The block SHALL detect the vb edge as vb=1 while a registered copy vb_l=0.
REQ-013 The block SHALL change sel only in the cycle after a detected vb edge, never during active video.
REQ-014 The block SHALL implement the states IDLE, RUN and LOCK.
REQ-015 IDLE->RUN SHALL occur when run=1; RUN->IDLE SHALL occur when run=0; on leaving RUN the frame counter SHALL clear.
REQ-016 IDLE/RUN->LOCK SHALL occur on lock; LOCK->RUN (run=1) or IDLE (run=0) SHALL occur on unlock.
REQ-017 If lock and unlock are high in the same cycle, lock SHALL win: the block enters or stays in LOCK.
REQ-018 In RUN, an 8-bit frame counter SHALL increment on each vb edge; when it equals PERIOD-1 on an edge, sel SHALL advance and the counter SHALL clear.
REQ-019 With PERIOD=1, sel SHALL advance on every vb edge.
REQ-020 In IDLE or RUN, step SHALL set a single pending flag.
REQ-021 On the next vb edge, a set pending flag SHALL advance sel once, clear the flag and clear the frame counter.
REQ-022 Extra step pulses before that vb edge SHALL NOT accumulate.
REQ-023 If pending and a PERIOD expiry coincide on one edge, sel SHALL advance by exactly one.
REQ-024 A step in the same cycle as a vb edge SHALL be applied on that edge.
REQ-025 Advance SHALL be sel+1 modulo 24.
REQ-026 sel SHALL never take the values 24..31.
REQ-027 wrap SHALL be asserted for exactly the one cycle in which sel is updated from 23 to 0.
REQ-028 In LOCK, sel SHALL hold, step and run SHALL be ignored, pending SHALL clear, and the counter SHALL be held at 0.
REQ-029 locked SHALL be registered and equal (state==LOCK).

Reset
REQ-030 While rst is high, the block SHALL drive sel=0, locked=0, wrap=0, counter=0, pending=0, state=IDLE.
REQ-031 While rst is high, vb_l SHALL be 1, so that vb already high at reset release produces no edge.
REQ-032 rst asserted mid-operation, including in LOCK or with a step pending, SHALL abort immediately to the reset values with no wrap pulse.

Structure
REQ-033 The shared package SHALL hold NPERM=24, SELW=5, CNTW=8 and the state encoding typedef (IDLE, RUN, LOCK).
REQ-034 The block SHALL contain one natural sub-module, jtframe_sort_edge: the vb rising-edge detector with reset value 1.
REQ-035 jtframe_sort SHALL NOT be instantiated inside this block; the top level connects sel to it.

Verification
REQ-036 Bench scenario: PERIOD=3, run=1, 9 vb edges -> sel 0->1->2->3, each advance one cycle after the 3rd, 6th and 9th edge.
REQ-037 Bench scenario: run=0, step pulsed 3 times before one vb edge -> sel 0->1 only, pending cleared.
REQ-038 Bench scenario: PERIOD=1, run=1, 24 edges from sel=0 -> sel returns to 0, wrap high for exactly one cycle on the 24th edge.
REQ-039 Bench scenario: sel=5, lock, then 10 edges with run=1 and steps -> sel stays 5, locked=1.
REQ-040 Bench scenario: sel=5 in LOCK, lock and unlock pulsed in the same cycle -> stays LOCK.
REQ-041 Bench scenario: sel=5 in LOCK, unlock with run=1 -> RUN, counter restarts from 0.
REQ-042 Bench scenario: vb held high through rst release -> no advance until vb falls and rises again.
REQ-043 Bench scenario: rst pulsed while pending=1 and sel=17 -> sel=0, pending=0, state=IDLE.
